// File: rtl/digit_serial_add_sub.sv
// digit_serial_add_sub: digit-serial add/subtract with start/busy/done handshake; DIGIT_SERIAL_ADD_SUB_SATURATE_EN enables overflow clamping
module digit_serial_add_sub #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [0:WIDTH-1] x,
  input  logic [0:WIDTH-1] y,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [0:WIDTH-1] sum,
  output logic             carry_out,
  output logic             overflow
);
  localparam int N = WIDTH / DIGIT;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] xd, yd, a_r, b_r, s_r, shifted, res;
  logic [DIGIT-1:0] a_dig, b_dig, ds;
  logic c_r, c_n, msb_c, ov, last;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign xd[i] = x[i];
    assign yd[i] = y[i];
    assign sum[i] = s_r[i];
  end
  assign a_dig = a_r[DIGIT-1:0];
  assign b_dig = b_r[DIGIT-1:0];
  assign {c_n, ds} = {1'b0, a_dig} + {1'b0, b_dig} + (DIGIT+1)'(c_r);
  assign msb_c = a_dig[DIGIT-1] ^ b_dig[DIGIT-1] ^ ds[DIGIT-1];
  assign ov = msb_c ^ c_n;
  assign last = cnt == CW'(N - 1);
  assign shifted = (s_r >> DIGIT) | (WIDTH'(ds) << (WIDTH - DIGIT));
`ifdef DIGIT_SERIAL_ADD_SUB_SATURATE_EN
  assign res = ov ? (a_dig[DIGIT-1] ? WIDTH'(1) << (WIDTH - 1) : ~(WIDTH'(1) << (WIDTH - 1))) : shifted;
`else
  assign res = shifted;
`endif
  // accept latches operands, each RUN edge consumes one digit from the bottom, result fills from the top
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      cnt <= '0;
      a_r <= '0;
      b_r <= '0;
      c_r <= 1'b0;
      s_r <= '0;
      carry_out <= 1'b0;
      overflow <= 1'b0;
    end else if (state == RUN) begin
      a_r <= a_r >> DIGIT;
      b_r <= b_r >> DIGIT;
      c_r <= c_n;
      cnt <= cnt + CW'(1);
      s_r <= last ? res : shifted;
      if (last) begin
        state <= DONE;
        busy <= 1'b0;
        done <= 1'b1;
        carry_out <= c_n;
        overflow <= ov;
      end
    end else if (start) begin
      state <= RUN;
      busy <= 1'b1;
      done <= 1'b0;
      cnt <= '0;
      a_r <= xd;
      b_r <= sub ? ~yd : yd;
      c_r <= carry_in ^ sub;
      s_r <= '0;
      carry_out <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= IDLE;
      done <= 1'b0;
    end
  end
endmodule

// File: tb/tb_digit_serial_add_sub.sv
// tb_digit_serial_add_sub: directed and randomized checks against a behavioural arithmetic model
module tb_digit_serial_add_sub;
  localparam int W = 16;
  localparam int N = 4;
  typedef struct packed {logic [W-1:0] s; logic co; logic ov;} res_t;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, start16 = 1'b0, sub = 1'b0, carry_in = 1'b0;
  logic [0:W-1] x = '0, y = '0, sum, sum16;
  logic busy, done, carry_out, overflow, busy16, done16, co16, ov16;
  int n_cmp = 0, n_err = 0;
  bit checking = 1'b0;
  always #5 clk = ~clk;
  digit_serial_add_sub #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .reset(reset), .start(start), .sub(sub), .x(x), .y(y), .carry_in(carry_in),
    .busy(busy), .done(done), .sum(sum), .carry_out(carry_out), .overflow(overflow));
  digit_serial_add_sub #(.WIDTH(16), .DIGIT(16)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .sub(sub), .x(x), .y(y), .carry_in(carry_in),
    .busy(busy16), .done(done16), .sum(sum16), .carry_out(co16), .overflow(ov16));
  function automatic logic [0:W-1] to_asc(input logic [W-1:0] v);
    logic [0:W-1] r;
    for (int i = 0; i < W; i++) r[i] = v[i];
    return r;
  endfunction
  function automatic logic [W-1:0] from_asc(input logic [0:W-1] v);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = v[i];
    return r;
  endfunction
  function automatic res_t ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input logic cin);
    int sa, sb, sr, ua, ub, c;
    res_t r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    ua = int'(a);
    ub = int'(b);
    c = int'(cin);
    if (s) begin
      sr = sa - sb - c;
      r.co = ua >= ub + c;
      r.s = W'(ua - ub - c);
    end else begin
      sr = sa + sb + c;
      r.co = ua + ub + c > 65535;
      r.s = W'(ua + ub + c);
    end
    r.ov = sr > 32767 || sr < -32768;
`ifdef DIGIT_SERIAL_ADD_SUB_SATURATE_EN
    if (r.ov) r.s = sr > 0 ? 16'h7fff : 16'h8000;
`endif
    return r;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  res_t m_res;
  logic m_busy, m_done, m_co, m_ov;
  logic [W-1:0] m_sum;
  int m_cnt;
  always @(posedge clk) begin
    if (reset) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_sum <= '0;
      m_co <= 1'b0;
      m_ov <= 1'b0;
      m_cnt <= 0;
    end else if (start && !m_busy) begin
      m_res <= ref_op(from_asc(x), from_asc(y), sub, carry_in);
      m_busy <= 1'b1;
      m_done <= 1'b0;
      m_cnt <= N;
      m_sum <= '0;
      m_co <= 1'b0;
      m_ov <= 1'b0;
    end else if (m_busy) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_sum <= m_res.s;
        m_co <= m_res.co;
        m_ov <= m_res.ov;
      end
    end else m_done <= 1'b0;
  end
  always @(negedge clk) begin
    if (checking) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("carry_out", 32'(carry_out), 32'(m_co));
      chk("overflow", 32'(overflow), 32'(m_ov));
      if (!m_busy) chk("sum", 32'(from_asc(sum)), 32'(m_sum));
    end
  end
  task automatic op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input logic cin,
                    input logic [W-1:0] es, input logic eco, input logic eov);
    int edges, bcnt;
    x = to_asc(a);
    y = to_asc(b);
    sub = s;
    carry_in = cin;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    edges = 1;
    bcnt = 0;
    while (!done && edges < 20) begin
      if (busy) bcnt++;
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    chk({nm, " latency"}, 32'(edges), 32'(N + 1));
    chk({nm, " busy cycles"}, 32'(bcnt), 32'(N));
    chk({nm, " sum"}, 32'(from_asc(sum)), 32'(es));
    chk({nm, " carry_out"}, 32'(carry_out), 32'(eco));
    chk({nm, " overflow"}, 32'(overflow), 32'(eov));
  endtask
  task automatic wait_done(input string nm);
    int k = 0;
    while (!done && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({nm, " done seen"}, 32'(done), 32'(1));
  endtask
  initial begin
    int edges, ndone;
    res_t r;
    r = ref_op(16'h1234, 16'h0ff1, 1'b0, 1'b0);
    chk("model add", 32'(r), {13'd0, 16'h2225, 1'b0, 1'b0});
    r = ref_op(16'h0005, 16'h0003, 1'b1, 1'b1);
    chk("model sub", 32'(r), {13'd0, 16'h0001, 1'b1, 1'b0});
    repeat (2) @(negedge clk);
    checking = 1'b1;
    chk("reset busy", 32'(busy), 32'(0));
    chk("reset done", 32'(done), 32'(0));
    chk("reset sum", 32'(from_asc(sum)), 32'(0));
    chk("reset flags", {30'd0, carry_out, overflow}, 32'(0));
    reset = 1'b0;
    @(negedge clk);
    op("add1", 16'h1234, 16'h0ff1, 1'b0, 1'b0, 16'h2225, 1'b0, 1'b0);
    @(negedge clk);
    op("carry", 16'hffff, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    @(negedge clk);
`ifdef DIGIT_SERIAL_ADD_SUB_SATURATE_EN
    op("sub ovf", 16'h7fff, 16'hffff, 1'b1, 1'b0, 16'h7fff, 1'b0, 1'b1);
`else
    op("sub ovf", 16'h7fff, 16'hffff, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1);
`endif
    @(negedge clk);
    op("sub borrow", 16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0);
    op("b2b", 16'h0100, 16'h0023, 1'b0, 1'b1, 16'h0124, 1'b0, 1'b0);
    @(negedge clk);
    x = to_asc(16'h1234);
    y = to_asc(16'h0ff1);
    sub = 1'b0;
    carry_in = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    x = to_asc(16'haaaa);
    y = to_asc(16'h5555);
    sub = 1'b1;
    carry_in = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignore");
    chk("ignore sum", 32'(from_asc(sum)), 32'h2225);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    chk("abort outs", {28'd0, busy, done, carry_out, overflow}, 32'(0));
    chk("abort sum", 32'(from_asc(sum)), 32'(0));
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort no done", 32'(ndone), 32'(0));
    op("post reset", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);
    @(negedge clk);
    x = to_asc(16'h1234);
    y = to_asc(16'h0ff1);
    sub = 1'b0;
    carry_in = 1'b1;
    start16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start16 = 1'b0;
    edges = 1;
    while (!done16 && edges < 20) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    chk("n1 latency", 32'(edges), 32'(2));
    chk("n1 sum", 32'(from_asc(sum16)), 32'h2226);
    chk("n1 flags", {30'd0, co16, ov16}, 32'(0));
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      reset = $urandom_range(0, 99) == 0;
      start = $urandom_range(0, 2) == 0;
      x = to_asc($urandom_range(0, 7) == 0 ? 16'h7fff : W'($urandom));
      y = to_asc($urandom_range(0, 7) == 0 ? 16'h8000 : W'($urandom));
      sub = 1'($urandom);
      carry_in = 1'($urandom);
    end
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    repeat (8) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
